// File: rtl/rv_lsu.sv
// Handshaked load/store unit: effective address, byte-lane strobes and replicated
// store data, load extraction with sign/zero extension, misalign/bus/timeout faults.
module rv_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_base,
  input  logic [11:0]       req_offset,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic [1:0]        rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rerr
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic              is_store;
  logic [2:0]        funct3_q;
  logic [LW-1:0]     lane_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   rdata_q;
  logic [1:0]        err_q;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [NB-1:0]     wstrb_q;

  logic [XLEN-1:0]   ea_full, wdata_rep, shifted, ext_mask, load_ext;
  logic [ADDR_W-1:0] ea;
  logic [LW-1:0]     lane;
  logic [7:0]        size_mask;
  logic [NB-1:0]     strb;
  logic              illegal, misaligned, fault, timeout_hit, ext_msb;

  always_comb begin
    ea_full = req_base + {{(XLEN-12){req_offset[11]}}, req_offset};
    ea      = ADDR_W'(ea_full);
    lane    = ea_full[LW-1:0];
    illegal = (req_funct3 == 3'b111) ||
              ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    wdata_rep = '0;
    case (req_funct3[1:0])
      2'b00: begin
        size_mask  = 8'h01;
        misaligned = 1'b0;
        for (int unsigned i = 0; i < NB; i++) wdata_rep[8*i +: 8] = req_wdata[7:0];
      end
      2'b01: begin
        size_mask  = 8'h03;
        misaligned = ea_full[0];
        for (int unsigned i = 0; i < NB/2; i++) wdata_rep[16*i +: 16] = req_wdata[15:0];
      end
      2'b10: begin
        size_mask  = 8'h0F;
        misaligned = |ea_full[1:0];
        for (int unsigned i = 0; i < NB/4; i++) wdata_rep[32*i +: 32] = req_wdata[31:0];
      end
      default: begin
        size_mask  = 8'hFF;
        misaligned = |ea_full[2:0];
        wdata_rep  = req_wdata;
      end
    endcase
    fault = illegal || misaligned;
    strb  = NB'(size_mask) << lane;
  end

  // Load path works from the captured lane/size, not the live request inputs.
  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   begin ext_mask = XLEN'(8'hFF);          ext_msb = shifted[7];  end
      2'b01:   begin ext_mask = XLEN'(16'hFFFF);       ext_msb = shifted[15]; end
      2'b10:   begin ext_mask = XLEN'(32'hFFFF_FFFF);  ext_msb = shifted[31]; end
      default: begin ext_mask = '1;                    ext_msb = 1'b0;        end
    endcase
    load_ext = shifted & ext_mask;
    if (!funct3_q[2] && ext_msb) load_ext = load_ext | ~ext_mask;
  end

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (req_valid) state_nx = fault ? RESP : ISSUE;
      ISSUE: if (mem_ready) state_nx = is_store ? RESP : WAIT;
             else if (timeout_hit) state_nx = RESP;
      WAIT:  if (mem_rvalid || timeout_hit) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !reset;
    mem_valid = (state == ISSUE);
    rsp_valid = (state == RESP);
    mem_we    = is_store;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
    rsp_rdata = rdata_q;
    rsp_rd    = rd_q;
    rsp_err   = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store <= 1'b0;
      funct3_q <= '0;
      lane_q   <= '0;
      rd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
      tcnt     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          is_store <= req_store;
          funct3_q <= req_funct3;
          lane_q   <= lane;
          rd_q     <= req_rd;
          rdata_q  <= '0;
          err_q    <= fault ? 2'b01 : 2'b00;
          tcnt     <= '0;
          addr_q   <= ea & ~ADDR_W'(NB - 1);
          wdata_q  <= wdata_rep;
          wstrb_q  <= req_store ? strb : '0;
        end
        ISSUE: begin
          tcnt <= tcnt + 1'b1;
          if (!mem_ready && timeout_hit) err_q <= 2'b11;
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (mem_rvalid) begin
            if (mem_rerr) err_q <= 2'b10;
            else          rdata_q <= load_ext;
          end else if (timeout_hit) begin
            err_q <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: a 32-bit instance and a 64-bit instance (TIMEOUT 4) share one
// stimulus bus; expectations come from an arithmetic reference model.
module tb_rv_lsu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_store = 1'b0, rsp_ready = 1'b0;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0, mem_rerr = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_base = '0, req_wdata = '0, mem_rdata = '0;
  logic [11:0] req_offset = '0;
  logic [4:0]  req_rd = '0;
  bit          sel64 = 1'b0;

  int vectors = 0, miscompares = 0;

  logic        a_req_ready, a_rsp_valid, a_mem_valid, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [4:0]  a_rsp_rd;
  logic [1:0]  a_rsp_err;
  logic [3:0]  a_mem_wstrb;
  logic        b_req_ready, b_rsp_valid, b_mem_valid, b_mem_we;
  logic [63:0] b_rsp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [4:0]  b_rsp_rd;
  logic [1:0]  b_rsp_err;
  logic [7:0]  b_mem_wstrb;

  logic        o_req_ready, o_rsp_valid, o_mem_valid, o_mem_we;
  logic [63:0] o_rsp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [4:0]  o_rsp_rd;
  logic [1:0]  o_rsp_err;
  logic [7:0]  o_mem_wstrb;

  rv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(255)) u32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel64), .req_ready(a_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base[31:0]), .req_offset(req_offset),
    .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel64), .rsp_rdata(a_rsp_rdata),
    .rsp_rd(a_rsp_rd), .rsp_err(a_rsp_err),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready & ~sel64), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_rvalid(mem_rvalid & ~sel64), .mem_rdata(mem_rdata[31:0]), .mem_rerr(mem_rerr)
  );

  rv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel64), .req_ready(b_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel64), .rsp_rdata(b_rsp_rdata),
    .rsp_rd(b_rsp_rd), .rsp_err(b_rsp_err),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready & sel64), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_rvalid(mem_rvalid & sel64), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
  );

  always_comb begin
    if (sel64) begin
      o_req_ready = b_req_ready; o_rsp_valid = b_rsp_valid; o_mem_valid = b_mem_valid;
      o_mem_we = b_mem_we; o_rsp_rdata = b_rsp_rdata; o_mem_wdata = b_mem_wdata;
      o_mem_addr = b_mem_addr; o_rsp_rd = b_rsp_rd; o_rsp_err = b_rsp_err;
      o_mem_wstrb = b_mem_wstrb;
    end else begin
      o_req_ready = a_req_ready; o_rsp_valid = a_rsp_valid; o_mem_valid = a_mem_valid;
      o_mem_we = a_mem_we; o_rsp_rdata = {32'h0, a_rsp_rdata};
      o_mem_wdata = {32'h0, a_mem_wdata}; o_mem_addr = a_mem_addr; o_rsp_rd = a_rsp_rd;
      o_rsp_err = a_rsp_err; o_mem_wstrb = {4'h0, a_mem_wstrb};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  err;
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;
    int          mcyc;
  } exp_t;

  // lat: cycles after the accept edge until rsp_valid is first seen.
  function automatic exp_t model(input bit x64, input bit st, input logic [2:0] f3,
                                 input logic [63:0] base, input logic [11:0] off,
                                 input logic [63:0] wd, input logic [63:0] mrd,
                                 input bit merr, input int unsigned mstall, input bit tmo);
    exp_t e;
    int unsigned nb, size, lane;
    logic [63:0] sum, m, v;
    logic [31:0] ea;
    e = '{err: 2'd0, addr: 32'd0, strb: 8'd0, wdata: 64'd0, rdata: 64'd0, lat: 0, mcyc: 0};
    nb   = x64 ? 8 : 4;
    size = 1 << f3[1:0];
    sum  = base + {{52{off[11]}}, off};
    ea   = sum[31:0];
    lane = ea % nb;
    if (f3 == 3'd7 || (!x64 && (f3 == 3'd3 || f3 == 3'd6)) || (ea % size) != 0) begin
      e.err = 2'd1;
      return e;
    end
    e.addr = ea - lane;
    e.mcyc = mstall + 1;
    if (st) begin
      e.strb = 8'(((1 << size) - 1) << lane);
      for (int i = 0; i < nb; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      e.lat = mstall + 1;
      return e;
    end
    if (tmo) begin
      e.err = 2'd3;
      e.lat = 4;
      return e;
    end
    e.lat = mstall + 2;
    if (merr) begin
      e.err = 2'd2;
      return e;
    end
    v = x64 ? mrd : {32'h0, mrd[31:0]};
    v = v >> (8 * lane);
    if (size < 8) begin
      m = (64'd1 << (8 * size)) - 64'd1;
      v = v & m;
      if (!f3[2] && v[8*size-1]) v = v | ~m;
    end
    if (!x64) v = v & 64'hFFFF_FFFF;
    e.rdata = v;
    return e;
  endfunction

  task automatic run_access(input string tag, input bit x64, input bit st, input logic [2:0] f3,
                            input logic [63:0] base, input logic [11:0] off,
                            input logic [63:0] wd, input logic [4:0] rd,
                            input logic [63:0] mrd, input bit merr,
                            input int unsigned mstall, input int unsigned rstall, input bit tmo);
    exp_t e;
    int k, first, mv, hs, rc;
    bit done, hs_next, take;
    e = model(x64, st, f3, base, off, wd, mrd, merr, mstall, tmo);
    sel64 = x64;
    @(negedge clk);
    chk({tag, " req_ready"}, 64'(o_req_ready), 64'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_base = base;
    req_offset = off; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0; first = -1; mv = 0; hs = 0; rc = 0; done = 1'b0;
    while (!done && k < 40) begin
      if (o_mem_valid) begin
        mv++;
        chk({tag, " mem_addr"}, 64'(o_mem_addr), 64'(e.addr));
        chk({tag, " mem_we"}, 64'(o_mem_we), 64'(st));
        chk({tag, " mem_wstrb"}, 64'(o_mem_wstrb), 64'(e.strb));
        if (st) chk({tag, " mem_wdata"}, o_mem_wdata, e.wdata);
      end
      if (o_rsp_valid) begin
        if (first < 0) begin
          first = k;
          chk({tag, " latency"}, 64'(first), 64'(e.lat));
        end
        rc++;
        chk({tag, " rsp_rdata"}, o_rsp_rdata, e.rdata);
        chk({tag, " rsp_rd"}, 64'(o_rsp_rd), 64'(rd));
        chk({tag, " rsp_err"}, 64'(o_rsp_err), 64'(e.err));
        chk({tag, " mem_valid in resp"}, 64'(o_mem_valid), 64'd0);
      end
      rsp_ready = o_rsp_valid && (rc > rstall);
      mem_ready = o_mem_valid && (mv > mstall);
      hs_next = mem_ready;
      take = rsp_ready;
      @(posedge clk); #1;
      k++;
      mem_ready = 1'b0; rsp_ready = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0;
      if (hs_next) begin
        hs++;
        if (!st && !tmo) begin
          mem_rvalid = 1'b1; mem_rdata = mrd; mem_rerr = merr;
        end
      end
      if (take) done = 1'b1;
    end
    mem_rvalid = 1'b0;
    chk({tag, " completed"}, 64'(done), 64'd1);
    chk({tag, " mem handshakes"}, 64'(hs), (e.err == 2'd1) ? 64'd0 : 64'd1);
    chk({tag, " mem_valid cycles"}, 64'(mv), 64'(e.mcyc));
    chk({tag, " idle again"}, 64'(o_req_ready), 64'd1);
  endtask

  initial begin
    bit x64, st, merr;
    logic [2:0] f3;
    logic [63:0] base, wd, mrd;
    logic [11:0] off;
    logic [4:0] rd;
    int unsigned mstall, rstall;

    #1 reset = 1'b1;
    #1;
    sel64 = 1'b0; #1;
    chk("reset req_ready32", 64'(o_req_ready), 64'd0);
    chk("reset rsp_valid32", 64'(o_rsp_valid), 64'd0);
    chk("reset mem_valid32", 64'(o_mem_valid), 64'd0);
    sel64 = 1'b1; #1;
    chk("reset req_ready64", 64'(o_req_ready), 64'd0);
    chk("reset rsp_rdata64", o_rsp_rdata, 64'd0);
    chk("reset mem_wstrb64", 64'(o_mem_wstrb), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_access("lw",    0, 0, 3'b010, 64'h100, 12'h004, 64'h0, 5'd7,  64'h8000_00FF, 0, 0, 0, 0);
    run_access("lb",    0, 0, 3'b000, 64'h100, 12'h003, 64'h0, 5'd3,  64'h80AB_CDEF, 0, 0, 0, 0);
    run_access("lbu",   0, 0, 3'b100, 64'h100, 12'h003, 64'h0, 5'd4,  64'h80AB_CDEF, 0, 0, 0, 0);
    run_access("sh",    0, 1, 3'b001, 64'h200, 12'hFFE, 64'h1234_ABCD, 5'd0, 64'h0, 0, 0, 0, 0);
    run_access("mis",   0, 0, 3'b010, 64'h100, 12'h002, 64'h0, 5'd5,  64'h0, 0, 0, 0, 0);
    run_access("f3111", 0, 0, 3'b111, 64'h100, 12'h000, 64'h0, 5'd6,  64'h0, 0, 0, 0, 0);
    run_access("lwu32", 0, 0, 3'b110, 64'h100, 12'h000, 64'h0, 5'd6,  64'h0, 0, 0, 0, 0);
    run_access("stall", 0, 0, 3'b101, 64'h300, 12'h006, 64'h0, 5'd11, 64'hBEEF_1234, 0, 3, 2, 0);
    run_access("berr",  0, 0, 3'b010, 64'h500, 12'h000, 64'h0, 5'd12, 64'hFFFF_FFFF, 1, 0, 0, 0);
    run_access("ld64",  1, 0, 3'b011, 64'h0,   12'h008, 64'h0, 5'd13, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 0);
    run_access("sd64",  1, 1, 3'b011, 64'h10,  12'hFF8, 64'h0123_4567_89AB_CDEF, 5'd1, 64'h0, 0, 1, 1, 0);
    run_access("tmo",   1, 0, 3'b010, 64'h40,  12'h000, 64'h0, 5'd14, 64'h0, 0, 0, 0, 1);

    // Reset while the 32-bit unit waits for read data.
    sel64 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_base = 64'h400; req_offset = 12'h010; req_rd = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst pre mem_valid", 64'(o_mem_valid), 64'd1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1; #1;
    chk("rst mem_valid", 64'(o_mem_valid), 64'd0);
    chk("rst rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst req_ready", 64'(o_req_ready), 64'd0);
    chk("rst mem_addr",  64'(o_mem_addr), 64'd0);
    chk("rst rsp_rd",    64'(o_rsp_rd), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) begin
      chk("rst late rvalid rsp_valid", 64'(o_rsp_valid), 64'd0);
      chk("rst late rvalid req_ready", 64'(o_req_ready), 64'd1);
      @(posedge clk); #1;
    end

    for (int n = 0; n < 150; n++) begin
      x64  = 1'($urandom_range(0, 1));
      st   = ($urandom_range(0, 2) == 0);
      f3   = 3'($urandom_range(0, 7));
      base = {$urandom, $urandom};
      off  = 12'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        base[2:0] = 3'd0;
        off[2:0]  = 3'd0;
      end
      wd     = {$urandom, $urandom};
      rd     = 5'($urandom);
      mrd    = {$urandom, $urandom};
      merr   = ($urandom_range(0, 7) == 0);
      mstall = x64 ? $urandom_range(0, 1) : $urandom_range(0, 3);
      rstall = $urandom_range(0, 2);
      run_access("rand", x64, st, f3, base, off, wd, rd, mrd, merr, mstall, rstall, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
